// File: rtl/bmu_core.sv
// Two-stage bit-manipulation execute unit: S1 captures and decodes, S2 computes into the registered outputs.
// Optional macro BMU_BITCOUNT_EN enables CLZ/CTZ/CPOP (opcode bits 16-18); otherwise those bits are illegal.
module bmu_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstL,
  input  logic             scanMode,
  input  logic             validIn,
  input  logic             ap,
  input  logic             csrRenIn,
  input  logic [WIDTH-1:0] csrRdataIn,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic [WIDTH-1:0] opcode,
  output logic [WIDTH-1:0] resultFf,
  output logic             error,
  output logic             validOut
);

  localparam int unsigned OP_W    = 5;
  localparam int unsigned SH_W    = 5;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned NUM_OPS = 24;

  localparam logic [OP_W-1:0] OP_AND   = 5'd0;
  localparam logic [OP_W-1:0] OP_OR    = 5'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 5'd3;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd4;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd5;
  localparam logic [OP_W-1:0] OP_SRA   = 5'd6;
  localparam logic [OP_W-1:0] OP_ROL   = 5'd7;
  localparam logic [OP_W-1:0] OP_ROR   = 5'd8;
  localparam logic [OP_W-1:0] OP_ANDN  = 5'd9;
  localparam logic [OP_W-1:0] OP_ORN   = 5'd10;
  localparam logic [OP_W-1:0] OP_XNOR  = 5'd11;
  localparam logic [OP_W-1:0] OP_MIN   = 5'd12;
  localparam logic [OP_W-1:0] OP_MAX   = 5'd13;
  localparam logic [OP_W-1:0] OP_MINU  = 5'd14;
  localparam logic [OP_W-1:0] OP_MAXU  = 5'd15;
`ifdef BMU_BITCOUNT_EN
  localparam logic [OP_W-1:0] OP_CLZ   = 5'd16;
  localparam logic [OP_W-1:0] OP_CTZ   = 5'd17;
  localparam logic [OP_W-1:0] OP_CPOP  = 5'd18;
`endif
  localparam logic [OP_W-1:0] OP_SEXTB = 5'd19;
  localparam logic [OP_W-1:0] OP_SEXTH = 5'd20;
  localparam logic [OP_W-1:0] OP_ZEXTH = 5'd21;
  localparam logic [OP_W-1:0] OP_REV8  = 5'd22;
  localparam logic [OP_W-1:0] OP_ORCB  = 5'd23;

  logic             w_onehot;
  logic             w_legal;
  logic [OP_W-1:0]  w_op_idx;

  logic             r_s1_valid;
  logic             r_s1_csr;
  logic             r_s1_ap;
  logic             r_s1_legal;
  logic [OP_W-1:0]  r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-1:0] r_s1_csr_data;

  logic [SH_W-1:0]    w_sh;
  logic [WIDTH-1:0]   w_add;
  logic [2*WIDTH-1:0] w_rol_x;
  logic [2*WIDTH-1:0] w_ror_x;
  logic [WIDTH-1:0]   w_orcb;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_s2_res;
  logic               w_s2_err;

  // One-hot check plus index of the set bit; reserved bits never decode legal.
  always_comb begin
    w_onehot = (opcode != '0) && ((opcode & (opcode - WIDTH'(1))) == '0);
    w_op_idx = '0;
    for (int i = 0; i < int'(NUM_OPS); i++) begin
      if (opcode[i]) w_op_idx = OP_W'(i);
    end
`ifdef BMU_BITCOUNT_EN
    w_legal = w_onehot && (opcode[WIDTH-1:NUM_OPS] == '0);
`else
    w_legal = w_onehot && (opcode[WIDTH-1:NUM_OPS] == '0) && (opcode[18:16] == 3'b000);
`endif
  end

  // S1 capture; scanMode freezes it and the incoming request is lost.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_s1_valid    <= 1'b0;
      r_s1_csr      <= 1'b0;
      r_s1_ap       <= 1'b0;
      r_s1_legal    <= 1'b0;
      r_s1_op       <= '0;
      r_s1_a        <= '0;
      r_s1_b        <= '0;
      r_s1_csr_data <= '0;
    end else if (!scanMode) begin
      r_s1_valid    <= validIn;
      r_s1_csr      <= csrRenIn;
      r_s1_ap       <= ap;
      r_s1_legal    <= w_legal;
      r_s1_op       <= w_op_idx;
      r_s1_a        <= aIn;
      r_s1_b        <= bIn;
      r_s1_csr_data <= csrRdataIn;
    end
  end

  always_comb begin
    w_sh    = r_s1_b[SH_W-1:0];
    w_add   = r_s1_ap ? (r_s1_a - r_s1_b) : (r_s1_a + r_s1_b);
    w_rol_x = {r_s1_a, r_s1_a} << w_sh;
    w_ror_x = {r_s1_a, r_s1_a} >> w_sh;
    w_orcb  = '0;
    for (int i = 0; i < int'(WIDTH / 8); i++) begin
      w_orcb[i*8 +: 8] = (r_s1_a[i*8 +: 8] != 8'h00) ? 8'hFF : 8'h00;
    end
  end

`ifdef BMU_BITCOUNT_EN
  logic [CNT_W-1:0] w_clz;
  logic [CNT_W-1:0] w_ctz;
  logic [CNT_W-1:0] w_cpop;

  // Highest set bit wins for CLZ, lowest for CTZ; all-zero input leaves 32.
  always_comb begin
    w_clz  = CNT_W'(WIDTH);
    w_ctz  = CNT_W'(WIDTH);
    w_cpop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (r_s1_a[i]) w_clz = CNT_W'(int'(WIDTH) - 1 - i);
      w_cpop = w_cpop + CNT_W'(r_s1_a[i]);
    end
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (r_s1_a[i]) w_ctz = CNT_W'(i);
    end
  end
`endif

  always_comb begin
    w_alu = '0;
    case (r_s1_op)
      OP_AND:   w_alu = r_s1_a & r_s1_b;
      OP_OR:    w_alu = r_s1_a | r_s1_b;
      OP_XOR:   w_alu = r_s1_a ^ r_s1_b;
      OP_ADD:   w_alu = w_add;
      OP_SLL:   w_alu = r_s1_a << w_sh;
      OP_SRL:   w_alu = r_s1_a >> w_sh;
      OP_SRA:   w_alu = WIDTH'($signed(r_s1_a) >>> w_sh);
      OP_ROL:   w_alu = w_rol_x[2*WIDTH-1:WIDTH];
      OP_ROR:   w_alu = w_ror_x[WIDTH-1:0];
      OP_ANDN:  w_alu = r_s1_a & ~r_s1_b;
      OP_ORN:   w_alu = r_s1_a | ~r_s1_b;
      OP_XNOR:  w_alu = ~(r_s1_a ^ r_s1_b);
      OP_MIN:   w_alu = ($signed(r_s1_a) < $signed(r_s1_b)) ? r_s1_a : r_s1_b;
      OP_MAX:   w_alu = ($signed(r_s1_a) > $signed(r_s1_b)) ? r_s1_a : r_s1_b;
      OP_MINU:  w_alu = (r_s1_a < r_s1_b) ? r_s1_a : r_s1_b;
      OP_MAXU:  w_alu = (r_s1_a > r_s1_b) ? r_s1_a : r_s1_b;
`ifdef BMU_BITCOUNT_EN
      OP_CLZ:   w_alu = WIDTH'(w_clz);
      OP_CTZ:   w_alu = WIDTH'(w_ctz);
      OP_CPOP:  w_alu = WIDTH'(w_cpop);
`endif
      OP_SEXTB: w_alu = {{(WIDTH-8){r_s1_a[7]}}, r_s1_a[7:0]};
      OP_SEXTH: w_alu = {{(WIDTH-16){r_s1_a[15]}}, r_s1_a[15:0]};
      OP_ZEXTH: w_alu = {{(WIDTH-16){1'b0}}, r_s1_a[15:0]};
      OP_REV8:  w_alu = {r_s1_a[7:0], r_s1_a[15:8], r_s1_a[23:16], r_s1_a[31:24]};
      OP_ORCB:  w_alu = w_orcb;
      default:  w_alu = '0;
    endcase
  end

  // CSR bypass overrides decode; illegal requests return zero with error.
  always_comb begin
    w_s2_res = w_alu;
    w_s2_err = 1'b0;
    if (r_s1_csr) begin
      w_s2_res = r_s1_csr_data;
    end else if (!r_s1_legal) begin
      w_s2_res = '0;
      w_s2_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      resultFf <= '0;
      error    <= 1'b0;
      validOut <= 1'b0;
    end else if (!scanMode) begin
      validOut <= r_s1_valid;
      if (r_s1_valid) begin
        resultFf <= w_s2_res;
        error    <= w_s2_err;
      end
    end
  end

endmodule

// File: tb/tb_bmu_core.sv
// Table-driven bench for bmu_core with an expected-result queue, plus reset and scan-hold sequences.
module tb_bmu_core;

  logic        clk;
  logic        rstL;
  logic        scanMode;
  logic        validIn;
  logic        ap;
  logic        csrRenIn;
  logic [31:0] csrRdataIn;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic [31:0] opcode;
  logic [31:0] resultFf;
  logic        error;
  logic        validOut;

  bmu_core #(.WIDTH(32)) dut (
    .clk(clk), .rstL(rstL), .scanMode(scanMode), .validIn(validIn), .ap(ap),
    .csrRenIn(csrRenIn), .csrRdataIn(csrRdataIn), .aIn(aIn), .bIn(bIn),
    .opcode(opcode), .resultFf(resultFf), .error(error), .validOut(validOut)
  );

`ifdef BMU_BITCOUNT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic        csr;
    logic        ap;
    logic [31:0] cd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  vec_t        vt[$];
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  logic [31:0] last_res = '0;
  logic        last_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops one expectation per validOut pulse, otherwise checks hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (validOut) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: got validOut=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", resultFf, e.res);
          chk("error", 32'(error), 32'(e.err));
          chk("latency", 32'(cyc), 32'(e.cyc));
          last_res = e.res;
          last_err = e.err;
        end
      end else begin
        chk("hold_result", resultFf, last_res);
        chk("hold_error", 32'(error), 32'(last_err));
      end
    end
  end

  task automatic add(input logic v, input logic csr, input logic a_p, input logic [31:0] cd,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] op,
                     input logic [31:0] er, input logic ee);
    vec_t t;
    t.v = v; t.csr = csr; t.ap = a_p; t.cd = cd; t.a = a; t.b = b; t.op = op;
    t.er = er; t.ee = ee;
    vt.push_back(t);
  endtask

  task automatic drive(input vec_t t, input int lat);
    @(negedge clk);
    scanMode   = 1'b0;
    validIn    = t.v;
    csrRenIn   = t.csr;
    ap         = t.ap;
    csrRdataIn = t.cd;
    aIn        = t.a;
    bIn        = t.b;
    opcode     = t.op;
    if (t.v) begin
      exp_t e;
      e.res = t.er;
      e.err = t.ee;
      e.cyc = cyc + lat;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      scanMode = 1'b0;
      validIn  = 1'b0;
      csrRenIn = 1'b0;
    end
  endtask

  initial begin
    vec_t t;
    rstL = 1'b1; scanMode = 1'b0; validIn = 1'b0; ap = 1'b0; csrRenIn = 1'b0;
    csrRdataIn = '0; aIn = '0; bIn = '0; opcode = '0;
    #1 rstL = 1'b0;
    #1;
    chk("reset_result", resultFf, 32'h0);
    chk("reset_error", 32'(error), 32'h0);
    chk("reset_valid", 32'(validOut), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstL = 1'b1;
    mon_en = 1'b1;

    //  v  csr ap  csrdata        a              b              opcode         exp            err
    add(1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00000008, 32'h00000000, 0);
    add(1, 0, 1, 32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00000008, 32'hFFFFFFFE, 0);
    add(1, 0, 0, 32'h0,        32'h80000001, 32'h00000021, 32'h00000040, 32'hC0000000, 0);
    add(1, 0, 0, 32'h0,        32'h80000001, 32'h00000021, 32'h00000080, 32'h00000003, 0);
    add(1, 0, 0, 32'h0,        32'h80000001, 32'h00000021, 32'h00000100, 32'hC0000000, 0);
    add(1, 0, 0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 32'h00000003, 32'h00000000, 1);
    add(1, 0, 0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 32'h01000000, 32'h00000000, 1);
    add(1, 0, 0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h00000000, 1);
    add(1, 1, 0, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 32'h00000003, 32'hDEADBEEF, 0);
    add(0, 0, 0, 32'h0,        32'h11111111, 32'h22222222, 32'h00000001, 32'h00000000, 0);
    add(1, 0, 0, 32'h0,        32'hF0F01234, 32'h0FF0FFFF, 32'h00000001, 32'h00F01234, 0);
    add(1, 0, 0, 32'h0,        32'h0000F000, 32'h0000000F, 32'h00000002, 32'h0000F00F, 0);
    add(1, 0, 0, 32'h0,        32'hAAAA5555, 32'hFFFF0000, 32'h00000004, 32'h55555555, 0);
    add(1, 0, 0, 32'h0,        32'h80000001, 32'h00000021, 32'h00000010, 32'h00000002, 0);
    add(1, 0, 0, 32'h0,        32'h80000001, 32'h00000021, 32'h00000020, 32'h40000000, 0);
    add(1, 0, 0, 32'h0,        32'h12345678, 32'h00000020, 32'h00000010, 32'h12345678, 0);
    add(1, 0, 0, 32'h0,        32'h12345678, 32'h00000000, 32'h00000080, 32'h12345678, 0);
    add(1, 0, 0, 32'h0,        32'h12345678, 32'h00000040, 32'h00000100, 32'h12345678, 0);
    add(1, 0, 0, 32'h0,        32'hFF00FF00, 32'h0F0F0F0F, 32'h00000200, 32'hF000F000, 0);
    add(1, 0, 0, 32'h0,        32'h000000FF, 32'hFFFF0000, 32'h00000400, 32'h0000FFFF, 0);
    add(1, 0, 0, 32'h0,        32'hFFFF0000, 32'hFF00FF00, 32'h00000800, 32'hFF0000FF, 0);
    add(1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00001000, 32'hFFFFFFFF, 0);
    add(1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00002000, 32'h00000001, 0);
    add(1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00004000, 32'h00000001, 0);
    add(1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00008000, 32'hFFFFFFFF, 0);
    add(1, 0, 0, 32'h0,        32'h00000000, 32'h0,          32'h00010000, BC ? 32'd32 : 32'd0, !BC);
    add(1, 0, 0, 32'h0,        32'h00010000, 32'h0,          32'h00010000, BC ? 32'd15 : 32'd0, !BC);
    add(1, 0, 0, 32'h0,        32'h00000100, 32'h0,          32'h00020000, BC ? 32'd8  : 32'd0, !BC);
    add(1, 0, 0, 32'h0,        32'h00000000, 32'h0,          32'h00020000, BC ? 32'd32 : 32'd0, !BC);
    add(1, 0, 0, 32'h0,        32'hF0F0F0F0, 32'h0,          32'h00040000, BC ? 32'd16 : 32'd0, !BC);
    add(1, 0, 0, 32'h0,        32'h00000080, 32'h0,          32'h00080000, 32'hFFFFFF80, 0);
    add(1, 0, 0, 32'h0,        32'h12348000, 32'h0,          32'h00100000, 32'hFFFF8000, 0);
    add(1, 0, 0, 32'h0,        32'hFFFF1234, 32'h0,          32'h00200000, 32'h00001234, 0);
    add(1, 0, 0, 32'h0,        32'h11223344, 32'h0,          32'h00400000, 32'h44332211, 0);
    add(1, 0, 0, 32'h0,        32'h00100001, 32'h0,          32'h00800000, 32'h00FF00FF, 0);
    add(1, 0, 0, 32'h0,        32'h00000001, 32'h00000001, 32'h80000000, 32'h00000000, 1);
    add(1, 1, 0, 32'hCAFEF00D, 32'h00000001, 32'h00000001, 32'h00000000, 32'hCAFEF00D, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'h0,          32'h0,          32'h0,        0);
    add(1, 0, 0, 32'h0,        32'h7FFFFFFF, 32'h00000001, 32'h00000008, 32'h80000000, 0);

    for (int i = 0; i < vt.size(); i++) drive(vt[i], 2);
    idle(4);

    // Scan hold: R1 sits in S1 across three frozen edges; requests under scan are dropped.
    t.v = 1; t.csr = 0; t.ap = 0; t.cd = '0; t.a = 32'h0000FFFF; t.b = 32'h00FF00FF;
    t.op = 32'h1; t.er = 32'h000000FF; t.ee = 0;
    drive(t, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      scanMode = 1'b1;
      validIn  = 1'b1;
      csrRenIn = (i == 1);
      csrRdataIn = 32'h55AA55AA;
      aIn = 32'h0F0F0F0F + 32'(i);
      bIn = 32'h1;
      opcode = 32'h4;
    end
    idle(6);

    // Reset with requests in flight: outputs clear at once and nothing emerges afterwards.
    t.v = 1; t.csr = 0; t.ap = 0; t.cd = '0; t.a = 32'd5; t.b = 32'd7;
    t.op = 32'h8; t.er = 32'd12; t.ee = 0;
    drive(t, 2);
    t.a = 32'hFFFF0000; t.b = 32'h0000FFFF; t.op = 32'h4; t.er = 32'hFFFFFFFF;
    drive(t, 2);
    t.a = 32'h1; t.b = 32'h1; t.op = 32'h1; t.er = 32'h1;
    drive(t, 2);
    #2;
    mon_en = 1'b0;
    rstL = 1'b0;
    validIn = 1'b0;
    #1;
    chk("midreset_result", resultFf, 32'h0);
    chk("midreset_error", 32'(error), 32'h0);
    chk("midreset_valid", 32'(validOut), 32'h0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rstL = 1'b1;
    last_res = '0;
    last_err = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_reset_valid", 32'(validOut), 32'h0);
    end

    t.v = 1; t.csr = 0; t.ap = 1; t.cd = '0; t.a = 32'd3; t.b = 32'd5;
    t.op = 32'h8; t.er = 32'hFFFFFFFE; t.ee = 0;
    drive(t, 2);
    idle(1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d results outstanding expected 0", q.size());
    end
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
